// File: rtl/booth_mult_ctrl_if.sv
// Operand/result bundle between the pipeline and the Booth multiply sequencer.
// No latency of its own: wires only.
// No backpressure: start is ignored while busy, result is qualified by data_resultRDY.
interface booth_mult_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_start;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             busy;
  logic             data_resultRDY;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;

  // Pipeline side: issues operands, consumes the result.
  modport master (
    output ctrl_start, data_operandA, data_operandB,
    input  busy, data_resultRDY, data_result, data_exception
  );

  // Multiplier side.
  modport slave (
    input  ctrl_start, data_operandA, data_operandB,
    output busy, data_resultRDY, data_result, data_exception
  );
endinterface

// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth multiplier sequencer: one add/sub/nop plus arithmetic shift per RUN cycle.
// Latency: start in cycle 0, busy cycles 1..WIDTH, data_resultRDY pulse in cycle WIDTH+1.
// Backpressure: none; ctrl_start is only sampled in IDLE/DONE, the pipeline stalls on busy.
module booth_mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic             clock,
  input logic             clr,
  booth_mult_ctrl_if.slave bus
);

  localparam int W = WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [2*W:0]     p, p_nxt;     // {high half, multiplier/low half, Booth guard bit}
  logic [W-1:0]     m, m_nxt;     // multiplicand
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Add/sub runs one bit wider than the operands so M = -2^(W-1) never overflows.
  logic [W:0]       hi_ext;
  logic [W:0]       m_ext;
  logic [W:0]       u;

  // State, product, multiplicand and counter registers; clr aborts everything at once.
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      p     <= '0;
      m     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      p     <= p_nxt;
      m     <= m_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and one Booth iteration: select on P[1:0], then shift {U, P[W:1]}.
  always_comb begin
    state_nxt = state;
    p_nxt     = p;
    m_nxt     = m;
    cnt_nxt   = cnt;
    hi_ext    = {p[2*W], p[2*W:W+1]};
    m_ext     = {m[W-1], m};
    u         = hi_ext;

    case (p[1:0])
      2'b01:   u = hi_ext + m_ext;
      2'b10:   u = hi_ext - m_ext;
      default: u = hi_ext;
    endcase

    case (state)
      IDLE, DONE: begin
        // DONE also accepts a start so back-to-back multiplies lose no cycle.
        if (bus.ctrl_start) begin
          p_nxt     = {{W{1'b0}}, bus.data_operandB, 1'b0};
          m_nxt     = bus.data_operandA;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        p_nxt   = {u, p[W:1]};
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(W - 1)) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result and overflow flag come straight from P and stay put until the next start.
  assign bus.busy           = (state == RUN);
  assign bus.data_resultRDY = (state == DONE);
  assign bus.data_result    = p[W:1];
  assign bus.data_exception = (p[2*W:W+1] != {W{p[W]}});

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Scoreboard bench for booth_mult_ctrl: expected product/flag/ready-cycle queued at start,
// popped and compared on every data_resultRDY pulse.
// Inputs driven and outputs sampled on the falling edge.
module tb_booth_mult_ctrl;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             exc;
    int               cyc;
    string            tag;
  } exp_t;

  logic   clock;
  logic   clr;
  int     cyc;
  int     checks;
  int     errors;
  exp_t   sb[$];

  booth_mult_ctrl_if #(.WIDTH(WIDTH)) ifc ();

  booth_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clock (clock),
    .clr   (clr),
    .bus   (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle index: the cycle after the k-th rising edge is cycle k.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: full 64-bit signed product, low half and fits-in-32 check.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int rdy_cyc, input string tag);
    exp_t e;
    logic signed [63:0] sa, sb_, pr;
    sa    = {{32{a[31]}}, a};
    sb_   = {{32{b[31]}}, b};
    pr    = sa * sb_;
    e.res = pr[31:0];
    e.exc = (pr[63:32] != {32{pr[31]}});
    e.cyc = rdy_cyc;
    e.tag = tag;
    return e;
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (ifc.data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_rdy", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_res"}, 64'(ifc.data_result), 64'(e.res));
        chk({e.tag, "_exc"}, 64'(ifc.data_exception), 64'(e.exc));
        chk({e.tag, "_rdy_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Raise start for one cycle with the given operands and queue the expectation.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    ifc.data_operandA = a;
    ifc.data_operandB = b;
    ifc.ctrl_start    = 1'b1;
    sb.push_back(model(a, b, cyc + LAT, tag));
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3 * LAT) begin
      @(negedge clock);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Full operation from IDLE; operands are scrambled during RUN to prove they are not re-read.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    @(negedge clock);
    issue(a, b, tag);
    @(negedge clock);
    ifc.ctrl_start    = 1'b0;
    ifc.data_operandA = $urandom;
    ifc.data_operandB = $urandom;
    wait_empty();
  endtask

  initial begin
    int c0;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-1:0] corner[6];

    cyc    = 0;
    checks = 0;
    errors = 0;
    clr    = 1'b0;
    ifc.ctrl_start    = 1'b0;
    ifc.data_operandA = '0;
    ifc.data_operandB = '0;

    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(ifc.busy), 64'd0);
    chk("rst_rdy",  64'(ifc.data_resultRDY), 64'd0);
    chk("rst_res",  64'(ifc.data_result), 64'd0);
    chk("rst_exc",  64'(ifc.data_exception), 64'd0);
    clr = 1'b1;
    repeat (2) @(negedge clock);

    // 1: latency and busy window
    c0 = cyc;
    issue(32'd3, 32'd5, "t1");
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clock);
      ifc.ctrl_start = 1'b0;
      chk($sformatf("t1_busy_c%0d", k), 64'(ifc.busy), (k <= WIDTH) ? 64'd1 : 64'd0);
    end
    wait_empty();

    // 2, 3: signs, most-negative operand, overflow flag
    do_op(32'hFFFF_FFF9, 32'd6, "t2_neg");
    do_op(32'h8000_0000, 32'd1, "t2_min");
    do_op(32'h7FFF_FFFF, 32'd2, "t3_ovf");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, "t3_minxm1");

    // 4: start during RUN ignored, start during DONE accepted back to back
    @(negedge clock);
    c0 = cyc;
    issue(32'd3, 32'd5, "t4_a");
    while (cyc < c0 + 10) @(negedge clock);
    ifc.ctrl_start = 1'b0;
    ifc.ctrl_start    = 1'b1;
    ifc.data_operandA = 32'd9;
    ifc.data_operandB = 32'd9;
    @(negedge clock);
    ifc.ctrl_start = 1'b0;
    while (cyc < c0 + LAT && cyc < c0 + 3 * LAT) @(negedge clock);
    #2;
    chk("t4_rdy_seen", 64'(ifc.data_resultRDY), 64'd1);
    issue(32'd2, 32'd4, "t4_b");
    chk("t4_b_rdy_cycle_target", 64'(sb[0].cyc), 64'(c0 + 2 * LAT));
    @(negedge clock);
    ifc.ctrl_start = 1'b0;
    wait_empty();

    // 5: asynchronous abort mid-RUN, no ready pulse afterwards
    @(negedge clock);
    c0 = cyc;
    ifc.data_operandA = 32'd100;
    ifc.data_operandB = 32'd100;
    ifc.ctrl_start    = 1'b1;
    @(negedge clock);
    ifc.ctrl_start = 1'b0;
    while (cyc < c0 + 12) @(negedge clock);
    chk("t5_busy_before", 64'(ifc.busy), 64'd1);
    clr = 1'b0;
    #1;
    chk("t5_busy_abort", 64'(ifc.busy), 64'd0);
    chk("t5_res_abort",  64'(ifc.data_result), 64'd0);
    chk("t5_exc_abort",  64'(ifc.data_exception), 64'd0);
    repeat (2) @(negedge clock);
    clr = 1'b1;
    repeat (LAT + 5) @(negedge clock);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "t5_m1m1");

    // 6: random and corner operands
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;
    corner[5] = 32'h0001_0000;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        do_op(corner[i], corner[j], "t6_corner");
      end
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = corner[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) rb = corner[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) ra = {{20{ra[11]}}, ra[11:0]};
      if ($urandom_range(0, 3) == 0) rb = {{20{rb[11]}}, rb[11:0]};
      do_op(ra, rb, "t6_rand");
    end

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
